// File: rtl/param_johnson_counter_pkg.sv
// ---------------------------------------------------------------------------
// param_johnson_counter_pkg
// Shared definitions for the Johnson-counter sequencer blocks.
//   dir_t          : count direction encoding (DIR_UP = 1, DIR_DOWN = 0)
//   calc_idx_w()   : width of a sequence index for an N-stage counter
//                    (the sequence has 2N positions)
// ---------------------------------------------------------------------------
package param_johnson_counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    function automatic int calc_idx_w(input int stages);
        return $clog2(2 * stages);
    endfunction

endpackage

// File: rtl/param_johnson_counter_stage_ff.sv
// ---------------------------------------------------------------------------
// jc_stage_ff
// One bit of the Johnson counter: a D flop with asynchronous active-low
// reset and a two-level input mux. The load path has priority over the
// step path; with neither selected the flop holds.
// Ports:
//   clk   in  1  rising-edge clock
//   rst   in  1  asynchronous active-low reset (q -> 0)
//   ld    in  1  take ld_d this cycle (load or recovery)
//   ld_d  in  1  value for the load path
//   en    in  1  take en_d this cycle (normal step)
//   en_d  in  1  value for the step path
//   q     out 1  registered bit
// ---------------------------------------------------------------------------
module jc_stage_ff
    import param_johnson_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ld,
    input  logic ld_d,
    input  logic en,
    input  logic en_d,
    output logic q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (ld) begin
            q <= ld_d;
        end else if (en) begin
            q <= en_d;
        end
    end

endmodule

// File: rtl/param_johnson_counter.sv
// ---------------------------------------------------------------------------
// param_johnson_counter
// N-stage Johnson counter used as a low-glitch sequencer/timebase. Counts up
// or down under enable, supports parallel load, decodes the sequence index,
// pulses wrap on the 2N-1 <-> 0 boundary and recovers from illegal codes.
// Parameters:
//   STAGES      number of flops N (>= 2); sequence period 2N
//   STICKY_ERR  0: err is a one-cycle pulse; 1: err holds until clr_err
// Ports:
//   clk       in  1       rising-edge clock
//   rst       in  1       asynchronous active-low reset
//   en        in  1       advance one step
//   up        in  1       direction (1 up, 0 down), sampled with en
//   load      in  1       parallel load of load_val, priority over en
//   load_val  in  STAGES  pattern to load
//   clr_err   in  1       clears sticky err
//   out       out STAGES  registered Johnson state
//   idx       out IDX_W   position of out in the sequence (combinational)
//   wrap      out 1       registered pulse after a boundary-crossing step
//   err       out 1       registered illegal-state / illegal-load flag
// ---------------------------------------------------------------------------
module param_johnson_counter
    import param_johnson_counter_pkg::*;
#(
    parameter int STAGES     = 4,
    parameter bit STICKY_ERR = 1'b0,
    localparam int IDX_W     = calc_idx_w(STAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [STAGES-1:0] load_val,
    input  logic              clr_err,
    output logic [STAGES-1:0] out,
    output logic [IDX_W-1:0]  idx,
    output logic              wrap,
    output logic              err
);

    // Code at index 2N-1 (MSB set, rest clear) and at index 0 (all clear).
    localparam logic [STAGES-1:0] TOP_CODE = {1'b1, {(STAGES-1){1'b0}}};
    localparam logic [STAGES-1:0] BOT_CODE = '0;

    // A legal Johnson code has at most one transition between adjacent bits.
    function automatic logic is_legal(input logic [STAGES-1:0] v);
        int trans;
        trans = 0;
        for (int i = 0; i < STAGES - 1; i++) begin
            if (v[i] != v[i+1]) trans++;
        end
        return (trans <= 1);
    endfunction

    logic [STAGES-1:0] state;
    logic [STAGES-1:0] step_val;
    logic [STAGES-1:0] force_val;
    logic              force_en;
    logic              out_legal;
    logic              ld_legal;
    logic              detect;
    logic              wrap_nxt;
    int                pop;
    int                idx_i;

    always_comb begin
        out_legal = is_legal(state);
        ld_legal  = is_legal(load_val);

        if (up == DIR_UP) begin
            step_val = {state[STAGES-2:0], ~state[STAGES-1]};
        end else begin
            step_val = {~state[0], state[STAGES-1:1]};
        end

        // Load and illegal-state recovery share the flop's priority path;
        // an illegal load collapses to the all-zero code.
        force_en  = load | ~out_legal;
        force_val = (load && ld_legal) ? load_val : '0;

        detect = load ? ~ld_legal : ~out_legal;

        // Only a genuine step may wrap; load and recovery never do.
        wrap_nxt = ~force_en & en &
                   (((up == DIR_UP) && (state == TOP_CODE)) ||
                    ((up == DIR_DOWN) && (state == BOT_CODE)));
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        jc_stage_ff u_ff (
            .clk  (clk),
            .rst  (rst),
            .ld   (force_en),
            .ld_d (force_val[i]),
            .en   (en),
            .en_d (step_val[i]),
            .q    (state[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            wrap <= wrap_nxt;
            if (STICKY_ERR) begin
                // A fresh detection wins over a simultaneous clear.
                err <= detect | (err & ~clr_err);
            end else begin
                err <= detect;
            end
        end
    end

    // Index decode: first half counts ones, second half counts down from 2N.
    always_comb begin
        pop   = $countones(state);
        idx_i = state[STAGES-1] ? (2 * STAGES - pop) : pop;
        idx   = idx_i[IDX_W-1:0];
    end

    assign out = state;

endmodule

// File: tb/tb_param_johnson_counter.sv
module tb_param_johnson_counter;

    logic clk;
    logic rst_n;

    // 4-stage, pulsed err
    logic       en, up, load, clr_err;
    logic [3:0] load_val;
    logic [3:0] out4;
    logic [2:0] idx4;
    logic       wrap4, err4;

    // 4-stage, sticky err
    logic       en_s, up_s, load_s, clr_s;
    logic [3:0] lv_s;
    logic [3:0] out_s;
    logic [2:0] idx_s;
    logic       wrap_s, err_s;

    // 5-stage
    logic       en5, up5, load5, clr5;
    logic [4:0] lv5;
    logic [4:0] out5;
    logic [3:0] idx5;
    logic       wrap5, err5;

    int vectors;
    int miscompares;

    logic [3:0] seq4 [8];
    logic [4:0] seq5 [10];

    param_johnson_counter #(.STAGES(4), .STICKY_ERR(1'b0)) u4 (
        .clk(clk), .rst(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .clr_err(clr_err),
        .out(out4), .idx(idx4), .wrap(wrap4), .err(err4)
    );

    param_johnson_counter #(.STAGES(4), .STICKY_ERR(1'b1)) u4s (
        .clk(clk), .rst(rst_n), .en(en_s), .up(up_s), .load(load_s),
        .load_val(lv_s), .clr_err(clr_s),
        .out(out_s), .idx(idx_s), .wrap(wrap_s), .err(err_s)
    );

    param_johnson_counter #(.STAGES(5), .STICKY_ERR(1'b0)) u5 (
        .clk(clk), .rst(rst_n), .en(en5), .up(up5), .load(load5),
        .load_val(lv5), .clr_err(clr5),
        .out(out5), .idx(idx5), .wrap(wrap5), .err(err5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        seq4 = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        seq5 = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                 5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};

        rst_n = 1'b0;
        en = 0; up = 0; load = 0; clr_err = 0; load_val = 4'b0000;
        en_s = 0; up_s = 0; load_s = 0; clr_s = 0; lv_s = 4'b0000;
        en5 = 0; up5 = 0; load5 = 0; clr5 = 0; lv5 = 5'b00000;

        #12;
        check("reset_out",  32'(out4),  32'h0);
        check("reset_idx",  32'(idx4),  32'h0);
        check("reset_wrap", 32'(wrap4), 32'h0);
        check("reset_err",  32'(err4),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Up count through a full period
        en = 1; up = 1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("up_out",  32'(out4),  32'(seq4[i % 8]));
            check("up_idx",  32'(idx4),  32'(i % 8));
            check("up_wrap", 32'(wrap4), (i == 8) ? 32'h1 : 32'h0);
        end

        // Down count from reset
        @(negedge clk);
        up = 0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        check("dn_first_out",  32'(out4),  32'h8);
        check("dn_first_idx",  32'(idx4),  32'h7);
        check("dn_first_wrap", 32'(wrap4), 32'h1);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("dn_out",  32'(out4),  32'(seq4[7 - i]));
            check("dn_idx",  32'(idx4),  32'(7 - i));
            check("dn_wrap", 32'(wrap4), 32'h0);
        end

        // Legal load beats enable, then hold
        load = 1; load_val = 4'b0111; en = 1;
        tick();
        check("load_out",  32'(out4),  32'h7);
        check("load_idx",  32'(idx4),  32'h3);
        check("load_wrap", 32'(wrap4), 32'h0);
        check("load_err",  32'(err4),  32'h0);
        load = 0; en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_out", 32'(out4), 32'h7);
        end

        // Illegal load
        load = 1; load_val = 4'b0110;
        tick();
        check("illload_out", 32'(out4), 32'h0);
        check("illload_err", 32'(err4), 32'h1);
        load = 0;
        tick();
        check("illload_err_pulse", 32'(err4), 32'h0);
        check("illload_out_hold",  32'(out4), 32'h0);

        // Load suppresses the wrap a down step from 0 would produce
        load = 1; load_val = 4'b0001; en = 1; up = 0;
        tick();
        check("loadwrap_out",  32'(out4),  32'h1);
        check("loadwrap_wrap", 32'(wrap4), 32'h0);
        load = 0;

        // Direction change with no dead cycle
        up = 1;
        tick();
        check("dir_up_out", 32'(out4), 32'h3);
        up = 0;
        tick();
        check("dir_dn_out", 32'(out4), 32'h1);
        check("dir_dn_idx", 32'(idx4), 32'h1);

        // Forced illegal state with en=0
        en = 0;
        @(negedge clk);
        force u4.g_stage[0].u_ff.q = 1'b0;
        force u4.g_stage[1].u_ff.q = 1'b1;
        force u4.g_stage[2].u_ff.q = 1'b0;
        force u4.g_stage[3].u_ff.q = 1'b1;
        #1;
        check("force_out", 32'(out4), 32'hA);
        tick();
        check("force_err", 32'(err4), 32'h1);
        release u4.g_stage[0].u_ff.q;
        release u4.g_stage[1].u_ff.q;
        release u4.g_stage[2].u_ff.q;
        release u4.g_stage[3].u_ff.q;
        tick();
        check("recover_out", 32'(out4), 32'h0);

        // Asynchronous reset between edges
        en = 1; up = 1;
        tick();
        tick();
        check("pre_rst_out", 32'(out4), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out",  32'(out4),  32'h0);
        check("async_rst_idx",  32'(idx4),  32'h0);
        check("async_rst_wrap", 32'(wrap4), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_out", 32'(out4), 32'h1);
        en = 0;

        // Sticky err
        load_s = 1; lv_s = 4'b0110;
        tick();
        check("sticky_out", 32'(out_s), 32'h0);
        check("sticky_err", 32'(err_s), 32'h1);
        load_s = 0;
        tick();
        check("sticky_hold1", 32'(err_s), 32'h1);
        tick();
        check("sticky_hold2", 32'(err_s), 32'h1);
        clr_s = 1;
        tick();
        check("sticky_clr", 32'(err_s), 32'h0);
        load_s = 1;
        tick();
        check("sticky_detect_wins", 32'(err_s), 32'h1);
        load_s = 0; clr_s = 0;
        tick();
        check("sticky_hold3", 32'(err_s), 32'h1);
        clr_s = 1;
        tick();
        check("sticky_clr2", 32'(err_s), 32'h0);
        clr_s = 0;

        // 5-stage: period 10
        en5 = 1; up5 = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("n5_out",  32'(out5),  32'(seq5[i % 10]));
            check("n5_idx",  32'(idx5),  32'(i % 10));
            check("n5_wrap", 32'(wrap5), ((i % 10) == 0) ? 32'h1 : 32'h0);
        end
        en5 = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
